bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder.sv | 174 +++++++++++++++++
 tb/tb_bus_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// bus_responder: memory and I/O responder for a small 8-bit CPU.
// After reset it sits in LOAD, holding the CPU in reset while a byte
// stream is written into internal RAM. The final byte moves it to RUN,
// where it answers CPU reads and writes with a one-cycle ready pulse.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   addr, wdata, rd, we   CPU bus request (sampled on clk)
//   rdata, ready          read data and one-cycle completion pulse
//   load_valid/data/last  program-load byte stream
//   load_ready            loader may present a byte
//   cpu_reset             holds the CPU in reset while loading
//   led                   LED register (IO_BASE+0)
//   timer_irq             timer interrupt (pending AND irq enable)
module bus_responder #(
  parameter int          RAM_DEPTH = 2048,
  parameter logic [15:0] IO_BASE   = 16'hFE00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rd,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic        ready,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_reset,
  output logic [7:0]  led,
  output logic        timer_irq
);

  localparam int          AW        = $clog2(RAM_DEPTH);
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);

  typedef enum logic {LOAD, RUN} state_t;

  state_t          state;
  logic [7:0]      ram [RAM_DEPTH];
  logic [AW-1:0]   ptr;
  logic [7:0]      count;
  logic [7:0]      reload;
  logic            tmr_en;
  logic            irq_en;
  logic            pending;

  logic            in_ram;
  logic            in_io;
  logic            is_vec;
  logic [15:0]     io_off;
  logic [7:0]      rd_data;
  logic [7:0]      ctrl_rd;
  logic            run_we;
  logic            led_wr;
  logic            reload_wr;
  logic            ctrl_wr;
  logic            expire;

  // Address decode and read mux. RAM has priority over the I/O window
  // in case a large RAM_DEPTH overlaps IO_BASE.
  always_comb begin
    in_ram  = {1'b0, addr} < RAM_LIMIT;
    io_off  = addr - IO_BASE;
    in_io   = !in_ram && (io_off[15:4] == 12'h000);
    is_vec  = !in_ram && !in_io && ((addr == 16'hFFFC) || (addr == 16'hFFFD));
    ctrl_rd = {pending, 5'b00000, irq_en, tmr_en};
    rd_data = 8'hFF;
    if (in_ram) begin
      rd_data = ram[addr[AW-1:0]];
    end else if (in_io) begin
      case (io_off[3:0])
        4'd0:    rd_data = led;
        4'd1:    rd_data = count;
        4'd2:    rd_data = reload;
        4'd3:    rd_data = ctrl_rd;
        default: rd_data = 8'hFF;
      endcase
    end else if (is_vec) begin
      rd_data = 8'h00;
    end
  end

  // A write always wins over a simultaneous read.
  always_comb begin
    run_we    = (state == RUN) && we;
    led_wr    = run_we && in_io && (io_off[3:0] == 4'd0);
    reload_wr = run_we && in_io && (io_off[3:0] == 4'd2);
    ctrl_wr   = run_we && in_io && (io_off[3:0] == 4'd3);
    expire    = tmr_en && (count == 8'h00);
  end

  // RAM write port shared by the loader and the CPU. It has no reset so
  // that loaded contents survive a reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state == LOAD) && load_valid) begin
        ram[ptr] <= load_data;
      end else if (run_we && in_ram) begin
        ram[addr[AW-1:0]] <= wdata;
      end
    end
  end

  // Control FSM, bus response and timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      ptr     <= '0;
      rdata   <= 8'h00;
      ready   <= 1'b0;
      led     <= 8'h00;
      count   <= 8'h00;
      reload  <= 8'h00;
      tmr_en  <= 1'b0;
      irq_en  <= 1'b0;
      pending <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        LOAD: begin
          if (load_valid) begin
            ptr <= ptr + AW'(1);
            if (load_last) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (rd || we) begin
            ready <= 1'b1;
            if (!we) begin
              rdata <= rd_data;
            end
          end
        end
        default: state <= LOAD;
      endcase

      if (led_wr) begin
        led <= wdata;
      end
      if (reload_wr) begin
        reload <= wdata;
      end
      if (ctrl_wr) begin
        tmr_en <= wdata[0];
        irq_en <= wdata[1];
      end

      // Reload is only copied into count on an enable edge or an expiry,
      // so a reload write never disturbs a countdown in progress.
      if (ctrl_wr && wdata[0] && !tmr_en) begin
        count <= reload;
      end else if (tmr_en) begin
        count <= expire ? reload : (count - 8'd1);
      end

      // An expiry in the same cycle as a clear keeps the flag set.
      if (expire) begin
        pending <= 1'b1;
      end else if (ctrl_wr && wdata[7]) begin
        pending <= 1'b0;
      end
    end
  end

  assign load_ready = (state == LOAD) && !reset;
  assign cpu_reset  = (state == LOAD);
  assign timer_irq  = pending && irq_en;

endmodule

// File: tb/tb_bus_responder.sv
// Testbench for bus_responder. Bus requests push their expected rdata
// into a scoreboard queue; a monitor pops and compares on every ready
// pulse. Level outputs (led, cpu_reset, load_ready, timer_irq) are
// checked directly from the stimulus sequence.
module tb_bus_responder;

  localparam logic [15:0] IO = 16'hFE00;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rd;
  logic        we;
  logic [7:0]  rdata;
  logic        ready;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset;
  logic [7:0]  led;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  bus_responder #(.RAM_DEPTH(2048), .IO_BASE(IO)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rd(rd), .we(we),
    .rdata(rdata), .ready(ready), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .cpu_reset(cpu_reset), .led(led), .timer_irq(timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus request per call; expected rdata goes to the scoreboard.
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [15:0] a, input logic [7:0] d,
                               input logic [7:0] exp_rdata);
    @(negedge clk);
    rd    = r;
    we    = w;
    addr  = a;
    wdata = d;
    if (r || w) sb.push_back(exp_rdata);
  endtask

  task automatic applyLoad(input logic [7:0] d, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rd         = 1'b0;
      we         = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
    end
  endtask

  // Scoreboard monitor: every ready pulse must match a queued request.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_ready: actual=1 required=0 at %0t", $time);
      end else begin
        checkOutput("rdata", 16'(rdata), 16'(sb.pop_front()));
      end
    end
  end

  logic [7:0] cnt_exp [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
  logic       irq_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; rd = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_load_ready", 16'(load_ready), 16'd0);
    checkOutput("rst_cpu_reset", 16'(cpu_reset), 16'd1);
    checkOutput("rst_ready", 16'(ready), 16'd0);
    checkOutput("rst_rdata", 16'(rdata), 16'h00);
    checkOutput("rst_led", 16'(led), 16'h00);
    checkOutput("rst_irq", 16'(timer_irq), 16'd0);
    reset = 1'b0;

    // Program load A9,05,EA
    applyLoad(8'hA9, 1'b0);
    checkOutput("load_ready_after_rst", 16'(load_ready), 16'd1);
    applyLoad(8'h05, 1'b0);
    applyLoad(8'hEA, 1'b1);
    checkOutput("cpu_reset_during_load", 16'(cpu_reset), 16'd1);
    idle(1);
    checkOutput("cpu_reset_run", 16'(cpu_reset), 16'd0);
    checkOutput("load_ready_run", 16'(load_ready), 16'd0);

    // Reads across the decode map
    applyStimulus(1, 0, 16'h0001, 8'h00, 8'h05);
    applyStimulus(1, 0, 16'h1234, 8'h00, 8'hFF);
    applyStimulus(1, 0, 16'hFFFC, 8'h00, 8'h00);
    applyStimulus(1, 0, 16'hFFFD, 8'h00, 8'h00);
    applyStimulus(1, 0, 16'h0000, 8'h00, 8'hA9);
    applyStimulus(1, 0, 16'h0002, 8'h00, 8'hEA);
    applyStimulus(1, 0, IO + 16'd5, 8'h00, 8'hFF);

    // LED write, rd+we priority, discarded writes
    applyStimulus(0, 1, IO, 8'h5A, 8'hFF);
    idle(1);
    checkOutput("led", 16'(led), 16'h5A);
    applyStimulus(1, 0, IO, 8'h00, 8'h5A);
    applyStimulus(1, 1, 16'h0010, 8'h77, 8'h5A);
    applyStimulus(1, 0, 16'h0010, 8'h00, 8'h77);
    applyStimulus(0, 1, 16'h1234, 8'h12, 8'h77);
    applyStimulus(1, 0, 16'h1234, 8'h00, 8'hFF);
    applyStimulus(0, 1, IO + 16'd1, 8'h99, 8'hFF);

    // Timer: reload=3, enable with irq -> count 3,2,1,0,3
    applyStimulus(0, 1, IO + 16'd2, 8'h03, 8'hFF);
    applyStimulus(0, 1, IO + 16'd3, 8'h03, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, IO + 16'd1, 8'h00, cnt_exp[i]);
      checkOutput("timer_irq_seq", 16'(timer_irq), 16'(irq_exp[i]));
    end
    // Clear away from an expiry, then clear coinciding with one
    applyStimulus(0, 1, IO + 16'd3, 8'h83, 8'h03);
    applyStimulus(1, 0, IO + 16'd3, 8'h00, 8'h03);
    checkOutput("irq_cleared", 16'(timer_irq), 16'd0);
    applyStimulus(0, 1, IO + 16'd3, 8'h83, 8'h03);
    applyStimulus(1, 0, IO + 16'd3, 8'h00, 8'h83);
    checkOutput("irq_set_wins", 16'(timer_irq), 16'd1);

    // Reload 0 expires every cycle; irq masked when irq enable is 0
    applyStimulus(0, 1, IO + 16'd3, 8'h00, 8'h83);
    applyStimulus(0, 1, IO + 16'd2, 8'h00, 8'h83);
    applyStimulus(0, 1, IO + 16'd3, 8'h81, 8'h83);
    applyStimulus(1, 0, IO + 16'd3, 8'h00, 8'h01);
    applyStimulus(1, 0, IO + 16'd3, 8'h00, 8'h81);
    applyStimulus(1, 0, IO + 16'd1, 8'h00, 8'h00);
    checkOutput("irq_masked", 16'(timer_irq), 16'd0);
    idle(2);

    // Reset in RUN and mid-load; rd held high must be ignored in LOAD
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst2_load_ready", 16'(load_ready), 16'd0);
    checkOutput("rst2_cpu_reset", 16'(cpu_reset), 16'd1);
    @(negedge clk);
    reset = 1'b0;
    rd    = 1'b1;
    addr  = 16'h0000;
    applyLoad(8'h11, 1'b0);
    applyLoad(8'h22, 1'b0);
    @(negedge clk);
    reset      = 1'b1;
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyLoad(8'h33, 1'b1);
    idle(1);
    checkOutput("cpu_reset_run2", 16'(cpu_reset), 16'd0);
    applyStimulus(1, 0, 16'h0000, 8'h00, 8'h33);
    applyStimulus(1, 0, 16'h0001, 8'h00, 8'h22);
    idle(3);

    checkOutput("sb_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
